// File: rtl/fft_output_unloader.sv
// Two-bank ping-pong unloader: captures 32 parallel FFT bins per load strobe and streams them out over valid/ready.
// Define FFT_OUT_BITREV_EN to emit bins in 5-bit bit-reversed order (o_index carries the reversed bin number).
module fft_output_unloader #(
  parameter int p_outputBits = 32,
  parameter int p_points     = 32,
  parameter int p_dropBits   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_load,
  input  logic [p_outputBits-1:0] i_X0,
  input  logic [p_outputBits-1:0] i_X1,
  input  logic [p_outputBits-1:0] i_X2,
  input  logic [p_outputBits-1:0] i_X3,
  input  logic [p_outputBits-1:0] i_X4,
  input  logic [p_outputBits-1:0] i_X5,
  input  logic [p_outputBits-1:0] i_X6,
  input  logic [p_outputBits-1:0] i_X7,
  input  logic [p_outputBits-1:0] i_X8,
  input  logic [p_outputBits-1:0] i_X9,
  input  logic [p_outputBits-1:0] i_X10,
  input  logic [p_outputBits-1:0] i_X11,
  input  logic [p_outputBits-1:0] i_X12,
  input  logic [p_outputBits-1:0] i_X13,
  input  logic [p_outputBits-1:0] i_X14,
  input  logic [p_outputBits-1:0] i_X15,
  input  logic [p_outputBits-1:0] i_X16,
  input  logic [p_outputBits-1:0] i_X17,
  input  logic [p_outputBits-1:0] i_X18,
  input  logic [p_outputBits-1:0] i_X19,
  input  logic [p_outputBits-1:0] i_X20,
  input  logic [p_outputBits-1:0] i_X21,
  input  logic [p_outputBits-1:0] i_X22,
  input  logic [p_outputBits-1:0] i_X23,
  input  logic [p_outputBits-1:0] i_X24,
  input  logic [p_outputBits-1:0] i_X25,
  input  logic [p_outputBits-1:0] i_X26,
  input  logic [p_outputBits-1:0] i_X27,
  input  logic [p_outputBits-1:0] i_X28,
  input  logic [p_outputBits-1:0] i_X29,
  input  logic [p_outputBits-1:0] i_X30,
  input  logic [p_outputBits-1:0] i_X31,
  output logic                    o_loadReady,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [p_outputBits-1:0] o_data,
  output logic [4:0]              o_index,
  output logic                    o_last,
  output logic                    o_overrun,
  output logic [p_dropBits-1:0]   o_dropCount
);

  localparam int unsigned P_N   = p_points;
  localparam int          IDX_W = $clog2(p_points);

  logic [p_outputBits-1:0] x_in [P_N];
  logic [p_outputBits-1:0] bank [2][P_N];
  logic [1:0]              full, full_next;
  logic                    wb, rb;
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    load_accept, beat, last_beat;

  assign x_in[0]  = i_X0;   assign x_in[1]  = i_X1;   assign x_in[2]  = i_X2;   assign x_in[3]  = i_X3;
  assign x_in[4]  = i_X4;   assign x_in[5]  = i_X5;   assign x_in[6]  = i_X6;   assign x_in[7]  = i_X7;
  assign x_in[8]  = i_X8;   assign x_in[9]  = i_X9;   assign x_in[10] = i_X10;  assign x_in[11] = i_X11;
  assign x_in[12] = i_X12;  assign x_in[13] = i_X13;  assign x_in[14] = i_X14;  assign x_in[15] = i_X15;
  assign x_in[16] = i_X16;  assign x_in[17] = i_X17;  assign x_in[18] = i_X18;  assign x_in[19] = i_X19;
  assign x_in[20] = i_X20;  assign x_in[21] = i_X21;  assign x_in[22] = i_X22;  assign x_in[23] = i_X23;
  assign x_in[24] = i_X24;  assign x_in[25] = i_X25;  assign x_in[26] = i_X26;  assign x_in[27] = i_X27;
  assign x_in[28] = i_X28;  assign x_in[29] = i_X29;  assign x_in[30] = i_X30;  assign x_in[31] = i_X31;

  function automatic logic [IDX_W-1:0] idx_of(input logic [IDX_W-1:0] c);
`ifdef FFT_OUT_BITREV_EN
    return {<<{c}};
`else
    return c;
`endif
  endfunction

  assign idx         = idx_of(cnt);
  assign o_valid     = full[rb];
  assign o_loadReady = ~full[wb];
  assign o_index     = idx;
  assign o_data      = bank[rb][idx];
  assign o_last      = o_valid & (cnt == IDX_W'(P_N - 1));

  // Accept/drop is decided on full[wb] before this cycle's drain clears a bank.
  assign load_accept = i_load & ~full[wb];
  assign beat        = o_valid & i_ready;
  assign last_beat   = beat & (cnt == IDX_W'(P_N - 1));

  always_comb begin
    full_next = full;
    if (load_accept) full_next[wb] = 1'b1;
    if (last_beat)   full_next[rb] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned i = 0; i < P_N; i++) begin
        bank[0][IDX_W'(i)] <= '0;
        bank[1][IDX_W'(i)] <= '0;
      end
      full        <= '0;
      wb          <= 1'b0;
      rb          <= 1'b0;
      cnt         <= '0;
      o_overrun   <= 1'b0;
      o_dropCount <= '0;
    end else begin
      o_overrun <= 1'b0;
      if (load_accept) begin
        for (int unsigned i = 0; i < P_N; i++) bank[wb][IDX_W'(i)] <= x_in[i];
        wb <= ~wb;
      end else if (i_load) begin
        o_overrun <= 1'b1;
        if (o_dropCount != '1) o_dropCount <= o_dropCount + 1'b1;
      end
      if (beat) cnt <= cnt + 1'b1;
      if (last_beat) rb <= ~rb;
      full <= full_next;
    end
  end

endmodule

// File: tb/tb_fft_output_unloader.sv
// Self-checking bench for fft_output_unloader: constant vector table, directed corner sequences and a random run
// checked against a frame-queue reference model.
module tb_fft_output_unloader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        i_load = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] x [32];
  logic        o_loadReady, o_valid, o_last, o_overrun;
  logic [31:0] o_data;
  logic [4:0]  o_index;
  logic [7:0]  o_dropCount;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of captured frames (capacity 2) plus position within the head frame.
  logic [1023:0] fq[$];
  int            pos = 0;
  logic          m_ovr = 1'b0;
  int            m_drop = 0;

  always #5 CLK = ~CLK;

  fft_output_unloader #(.p_outputBits(32), .p_points(32), .p_dropBits(8)) dut (
    .CLK(CLK), .RST(RST), .i_load(i_load),
    .i_X0(x[0]),   .i_X1(x[1]),   .i_X2(x[2]),   .i_X3(x[3]),   .i_X4(x[4]),   .i_X5(x[5]),
    .i_X6(x[6]),   .i_X7(x[7]),   .i_X8(x[8]),   .i_X9(x[9]),   .i_X10(x[10]), .i_X11(x[11]),
    .i_X12(x[12]), .i_X13(x[13]), .i_X14(x[14]), .i_X15(x[15]), .i_X16(x[16]), .i_X17(x[17]),
    .i_X18(x[18]), .i_X19(x[19]), .i_X20(x[20]), .i_X21(x[21]), .i_X22(x[22]), .i_X23(x[23]),
    .i_X24(x[24]), .i_X25(x[25]), .i_X26(x[26]), .i_X27(x[27]), .i_X28(x[28]), .i_X29(x[29]),
    .i_X30(x[30]), .i_X31(x[31]),
    .o_loadReady(o_loadReady), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_index(o_index), .o_last(o_last), .o_overrun(o_overrun), .o_dropCount(o_dropCount)
  );

  function automatic int ord(input int p);
    int r;
    r = p;
`ifdef FFT_OUT_BITREV_EN
    r = 0;
    for (int b = 0; b < 5; b++) if (((p >> b) & 1) != 0) r = r | (1 << (4 - b));
`endif
    return r;
  endfunction

  function automatic logic [31:0] pat(input int k);
    logic [15:0] re, im;
    re = 16'(k);
    im = 16'(-k);
    return {re, im};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_frame_pat();
    for (int k = 0; k < 32; k++) x[k] = pat(k);
  endtask

  task automatic set_frame_rand();
    for (int k = 0; k < 32; k++) x[k] = $urandom;
  endtask

  task automatic model_step();
    logic [1023:0] f;
    logic          acc, bt;
    if (!RST) begin
      fq.delete();
      pos    = 0;
      m_ovr  = 1'b0;
      m_drop = 0;
      return;
    end
    acc   = i_load && (fq.size() < 2);
    bt    = (fq.size() > 0) && i_ready;
    m_ovr = i_load && !acc;
    if (m_ovr && m_drop < 255) m_drop++;
    if (bt) begin
      if (pos == 31) begin
        void'(fq.pop_front());
        pos = 0;
      end else pos++;
    end
    if (acc) begin
      for (int k = 0; k < 32; k++) f[k*32 +: 32] = x[k];
      fq.push_back(f);
    end
  endtask

  task automatic model_check();
    logic [31:0] ed;
    chk("valid",     32'(o_valid),     32'(fq.size() > 0));
    chk("index",     32'(o_index),     ord(pos));
    chk("last",      32'(o_last),      32'((fq.size() > 0) && (pos == 31)));
    chk("loadReady", 32'(o_loadReady), 32'(fq.size() < 2));
    chk("overrun",   32'(o_overrun),   32'(m_ovr));
    chk("dropCount", 32'(o_dropCount), m_drop);
    if (fq.size() > 0) begin
      ed = fq[0][ord(pos)*32 +: 32];
      chk("data", o_data, ed);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    RST = 1'b0; i_load = 1'b0; i_ready = 1'b0;
    cycle();
    RST = 1'b1;
  endtask

  typedef struct {
    logic rst_n, load, ready;
    logic valid;
    int   beat;
    logic last, lr, ovr;
    int   drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lastp, c, acc, pulses;

    for (int k = 0; k < 32; k++) x[k] = '0;
    #2;

    // rst_n load ready | valid beat last loadReady overrun drop
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0};

    set_frame_pat();
    for (int i = 0; i < 7; i++) begin
      RST = tbl[i].rst_n; i_load = tbl[i].load; i_ready = tbl[i].ready;
      cycle();
      chk("tbl_valid",     32'(o_valid),     32'(tbl[i].valid));
      chk("tbl_index",     32'(o_index),     ord(tbl[i].beat));
      chk("tbl_last",      32'(o_last),      32'(tbl[i].last));
      chk("tbl_loadReady", 32'(o_loadReady), 32'(tbl[i].lr));
      chk("tbl_overrun",   32'(o_overrun),   32'(tbl[i].ovr));
      chk("tbl_dropCount", 32'(o_dropCount), tbl[i].drop);
      if (tbl[i].valid) chk("tbl_data", o_data, pat(ord(tbl[i].beat)));
    end
    chk("rst_data", o_data, 32'h0);

    // Single frame at full rate
    RST = 1'b1; set_frame_pat(); i_ready = 1'b1; i_load = 1'b1;
    cycle();
    i_load = 1'b0;
    n = 0; lastp = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) begin n++; if (o_last) lastp = n; end
      cycle();
    end
    chk("single_beats", n, 32);
    chk("single_last_pos", lastp, 32);

    // Backpressure 1,0,0,...
    do_reset();
    set_frame_pat(); i_load = 1'b1;
    cycle();
    i_load = 1'b0;
    c = 0; acc = 0; lastp = 0;
    while (o_valid && c < 200) begin
      i_ready = (c % 3 == 0);
      if (o_valid && i_ready) begin acc++; if (o_last) lastp = acc; end
      cycle();
      c++;
    end
    chk("bp_no_timeout", 32'(c < 200), 32'h1);
    chk("bp_beats", acc, 32);
    chk("bp_last_pos", lastp, 32);

    // Ping-pong: A, B three cycles later, C while A streams
    do_reset();
    i_ready = 1'b1;
    set_frame_rand(); i_load = 1'b1; cycle(); i_load = 1'b0;
    cycle(); cycle();
    set_frame_rand(); i_load = 1'b1; cycle(); i_load = 1'b0;
    cycle();
    set_frame_rand(); i_load = 1'b1; cycle(); i_load = 1'b0;
    pulses = (o_overrun === 1'b1) ? 1 : 0;
    n = 0;
    for (int k = 0; k < 80; k++) begin
      cycle();
      if (o_overrun) pulses++;
      if (o_valid) n++;
    end
    chk("pp_overrun_pulses", pulses, 1);
    chk("pp_dropCount", 32'(o_dropCount), 1);

    // Load coinciding with the last beat, other bank empty
    do_reset();
    i_ready = 1'b1;
    set_frame_rand(); i_load = 1'b1; cycle(); i_load = 1'b0;
    c = 0;
    while (!o_last && c < 40) begin cycle(); c++; end
    chk("sim_reached_last", 32'(o_last), 32'h1);
    set_frame_rand(); i_load = 1'b1;
    cycle();
    i_load = 1'b0;
    chk("sim_valid", 32'(o_valid), 32'h1);
    chk("sim_index", 32'(o_index), ord(0));
    chk("sim_drop", 32'(o_dropCount), 0);
    for (int k = 0; k < 34; k++) cycle();

    // Saturation of the drop counter
    do_reset();
    i_ready = 1'b0; set_frame_rand();
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      i_load = 1'b1;
      cycle();
      if (o_overrun) pulses++;
    end
    i_load = 1'b0;
    cycle();
    chk("sat_pulses", pulses, 298);
    chk("sat_dropCount", 32'(o_dropCount), 255);

    // Reset mid-frame
    do_reset();
    set_frame_pat(); i_ready = 1'b1; i_load = 1'b1; cycle(); i_load = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("mid_at_beat10", 32'(o_index), ord(10));
    RST = 1'b0;
    cycle();
    chk("mid_rst_valid",     32'(o_valid),     32'h0);
    chk("mid_rst_last",      32'(o_last),      32'h0);
    chk("mid_rst_overrun",   32'(o_overrun),   32'h0);
    chk("mid_rst_drop",      32'(o_dropCount), 0);
    chk("mid_rst_data",      o_data,           32'h0);
    chk("mid_rst_index",     32'(o_index),     0);
    chk("mid_rst_loadReady", 32'(o_loadReady), 32'h1);
    RST = 1'b1; set_frame_rand(); i_load = 1'b1;
    cycle();
    i_load = 1'b0;
    chk("mid_new_valid", 32'(o_valid), 32'h1);
    chk("mid_new_index", 32'(o_index), ord(0));
    for (int k = 0; k < 40; k++) cycle();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      RST     = ($urandom_range(0, 299) != 0);
      i_load  = ($urandom_range(0, 3) == 0);
      i_ready = ($urandom_range(0, 2) != 0);
      set_frame_rand();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
